// File: rtl/otter_mem_pkg.sv
// otter_mem_pkg
//   Shared types and helpers for the OTTER memory sequencer.
//   - mem_state_t : sequencer states
//   - F3_*        : funct3 access-size codes
//   - IR_NOP      : instruction register reset value (addi x0,x0,0)
//   - store_be / store_wdata / misaligned : access-size helpers
package otter_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DATA  = 2'd2,
      ST_TRAP  = 2'd3
   } mem_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [31:0] IR_NOP = 32'h0000_0013;

   // funct3[1:0] alone selects the size: 00 byte, 01 half, anything else word.
   // This also maps the unused codes (011, 110, 111) onto word accesses.
   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << a;
         2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
         default: be = 4'hF;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w;
      case (f3[1:0])
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic m;
      case (f3[1:0])
         2'b00:   m = 1'b0;
         2'b01:   m = a[0];
         default: m = (a != 2'b00);
      endcase
      return m;
   endfunction

endpackage

// File: rtl/otter_load_align.sv
// otter_load_align
//   Combinational load aligner: selects the byte/half lane from a bus word
//   and sign- or zero-extends it according to funct3.
//   Ports:
//     rdata  in  32  raw bus read word
//     a      in  2   low address bits of the load
//     funct3 in  3   access size / signedness
//     dout   out 32  aligned, extended load value
module otter_load_align
   import otter_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  a,
   input  logic [2:0]  funct3,
   output logic [31:0] dout
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      case (a)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      // Halfword lane uses a[1] only; a[0] is ignored here.
      half_v = a[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B:    dout = {{24{byte_v[7]}}, byte_v};
         F3_BU:   dout = {24'd0, byte_v};
         F3_H:    dout = {{16{half_v[15]}}, half_v};
         F3_HU:   dout = {16'd0, half_v};
         default: dout = rdata;
      endcase
   end

endmodule

// File: rtl/otter_mem_ctrl.sv
// otter_mem_ctrl
//   Memory sequencer between the OTTER control-unit FSM and a req/ack bus.
//   One bus transaction per request; a fetch and a data request seen together
//   run back to back (fetch first). mem_busy stalls the FSM.
//   Optional feature: define MISALIGN_TRAP_EN to reject misaligned accesses
//   with mem_err instead of silently forcing the low address bits.
//   Ports:
//     CLK, RST_N                  clock, async active-low reset
//     memRDEN1 / addr1            instruction fetch request
//     memRDEN2 / memWE2 / addr2   load / store request, din2 store data
//     ir14_12                     funct3 of the data access
//     ir, dout2                   last fetched word, last load result
//     mem_busy, mem_err           stall, sticky fault
//     bus_req/we/addr/be/wdata    registered bus request
//     bus_ack, bus_rdata          bus completion strobe and read data
module otter_mem_ctrl
   import otter_mem_pkg::*;
#(
   parameter int          TIMEOUT_CYC = 255,
   parameter logic [31:0] IR_RST      = IR_NOP
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        memRDEN1,
   input  logic        memRDEN2,
   input  logic        memWE2,
   input  logic [2:0]  ir14_12,
   input  logic [31:0] addr1,
   input  logic [31:0] addr2,
   input  logic [31:0] din2,
   output logic [31:0] ir,
   output logic [31:0] dout2,
   output logic        mem_busy,
   output logic        mem_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

`ifdef MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   localparam logic       TO_EN  = (TIMEOUT_CYC != 0);
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

   mem_state_t  state, nxt;
   logic [31:0] addr_d, din_d;
   logic [2:0]  f3_d;
   logic        we_d, pend_d;
   logic [7:0]  cnt, cnt_inc;

   logic        ack, tmo, data_req, any_req;
   logic [31:0] sel_addr, sel_din;
   logic [2:0]  sel_f3;
   logic        sel_we, sel_mis, fetch_mis;
   logic        issue_fetch, issue_data, trap;
   logic [31:0] load_val;

   // An ack with no request outstanding is not a completion.
   assign ack      = bus_ack & bus_req;
   assign data_req = memRDEN2 | memWE2;
   assign any_req  = memRDEN1 | data_req;
   assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   // Abort on the edge that would make the wait count reach the limit, so
   // bus_req stays high exactly TIMEOUT_CYC cycles.
   assign tmo      = TO_EN && bus_req && !ack && (cnt_inc == TO_LIM);

   // Data access source: live inputs when starting from idle, the latched
   // copy when it follows a fetch. Store wins over load.
   always_comb begin
      if (state == ST_IDLE) begin
         sel_addr = addr2;
         sel_din  = din2;
         sel_f3   = ir14_12;
         sel_we   = memWE2;
      end else begin
         sel_addr = addr_d;
         sel_din  = din_d;
         sel_f3   = f3_d;
         sel_we   = we_d;
      end
      sel_mis   = TRAP_EN && misaligned(sel_f3, sel_addr[1:0]);
      fetch_mis = TRAP_EN && (addr1[1:0] != 2'b00);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= ST_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: begin
            if (memRDEN1)      nxt = fetch_mis ? ST_TRAP : ST_FETCH;
            else if (data_req) nxt = sel_mis ? ST_TRAP : ST_DATA;
         end
         ST_FETCH: begin
            if (ack)      nxt = !pend_d ? ST_IDLE : (sel_mis ? ST_TRAP : ST_DATA);
            else if (tmo) nxt = ST_IDLE;
         end
         ST_DATA: begin
            if (ack || tmo) nxt = ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_busy    = (state != ST_IDLE);
      issue_fetch = (state == ST_IDLE) && (nxt == ST_FETCH);
      issue_data  = (state != ST_DATA) && (nxt == ST_DATA);
      trap        = (nxt == ST_TRAP);
   end

   otter_load_align u_align (
      .rdata  (bus_rdata),
      .a      (addr_d[1:0]),
      .funct3 (f3_d),
      .dout   (load_val)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ir        <= IR_RST;
         dout2     <= 32'd0;
         mem_err   <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'd0;
         bus_be    <= 4'd0;
         bus_wdata <= 32'd0;
         addr_d    <= 32'd0;
         din_d     <= 32'd0;
         f3_d      <= 3'd0;
         we_d      <= 1'b0;
         pend_d    <= 1'b0;
         cnt       <= 8'd0;
      end else begin
         // A new request clears the sticky fault; a fault raised on the same
         // edge (trap) takes precedence because it is assigned later.
         if (state == ST_IDLE && any_req) mem_err <= 1'b0;
         if (trap || tmo)                 mem_err <= 1'b1;

         if (state == ST_IDLE && data_req) begin
            addr_d <= addr2;
            din_d  <= din2;
            f3_d   <= ir14_12;
            we_d   <= memWE2;
         end

         if (issue_fetch)                             pend_d <= data_req;
         else if (state != ST_IDLE && (ack || tmo))   pend_d <= 1'b0;

         if (state != nxt) cnt <= 8'd0;
         else if (bus_req) cnt <= cnt_inc;

         if (issue_fetch) begin
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= {addr1[31:2], 2'b00};
            bus_be   <= 4'hF;
         end else if (issue_data) begin
            bus_req  <= 1'b1;
            bus_we   <= sel_we;
            bus_addr <= {sel_addr[31:2], 2'b00};
            bus_be   <= sel_we ? store_be(sel_f3, sel_addr[1:0]) : 4'hF;
            if (sel_we) bus_wdata <= store_wdata(sel_f3, sel_din);
         end else if (ack || tmo || trap) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
         end

         if (state == ST_FETCH && ack)         ir    <= bus_rdata;
         if (state == ST_DATA && ack && !we_d) dout2 <= load_val;
      end
   end

endmodule
